// File: rtl/chnl_rx_driver.sv
// ---------------------------------------------------------------------------
// chnl_rx_driver
//   Host-side initiator for one RIFFA channel RX interface. A START command
//   opens a receive transaction (CHNL_RX with LEN/OFF/LAST), waits for the
//   user logic to acknowledge it, streams an incrementing-word payload under
//   the VALID/REN handshake and then pulses DONE. If the acknowledge does not
//   arrive within C_ACK_TIMEOUT cycles, the transaction is abandoned and
//   TIMEOUT pulses instead. Used for loopback and bring-up of user channels
//   without a host driver.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   START               1-cycle command strobe, only looked at while idle
//   CMD_LEN/OFF/LAST    transaction descriptor, latched on START
//   CMD_SEED            value of payload word 0
//   BUSY                command in progress
//   DONE                1-cycle pulse, transfer completed
//   TIMEOUT             1-cycle pulse, acknowledge never came
//   CHNL_RX_CLK         forwarded CLK
//   CHNL_RX             transaction open
//   CHNL_RX_ACK         user accepts the transaction
//   CHNL_RX_LAST/LEN/OFF latched descriptor
//   CHNL_RX_DATA        payload beat, word k in bits [32k+31:32k]
//   CHNL_RX_DATA_VALID  beat valid
//   CHNL_RX_DATA_REN    user consumes the beat this cycle
// ---------------------------------------------------------------------------
module chnl_rx_driver #(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_ACK_TIMEOUT    = 1024
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        START,
  input  logic [31:0]                 CMD_LEN,
  input  logic [30:0]                 CMD_OFF,
  input  logic                        CMD_LAST,
  input  logic [31:0]                 CMD_SEED,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        TIMEOUT,
  output logic                        CHNL_RX_CLK,
  output logic                        CHNL_RX,
  input  logic                        CHNL_RX_ACK,
  output logic                        CHNL_RX_LAST,
  output logic [31:0]                 CHNL_RX_LEN,
  output logic [30:0]                 CHNL_RX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  output logic                        CHNL_RX_DATA_VALID,
  input  logic                        CHNL_RX_DATA_REN
);

  localparam int          BEAT_WORDS = C_PCI_DATA_WIDTH / 32;
  localparam logic [31:0] BEAT_W32   = 32'(BEAT_WORDS);
  localparam logic [31:0] TMO_LAST   = 32'(C_ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, FIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [30:0] off_q, off_d;
  logic        last_q, last_d;
  logic [31:0] seed_q, seed_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic        timeout_q, timeout_d;

  logic [31:0] remaining;
  logic [31:0] base_word;
  logic        last_beat;
  logic [C_PCI_DATA_WIDTH-1:0] beat_data;

  // cnt never passes len while streaming, so len - cnt cannot underflow and
  // the last-beat test stays correct for lengths right up to 2^32-1.
  assign remaining = len_q - cnt_q;
  assign base_word = seed_q + cnt_q;
  assign last_beat = (remaining <= BEAT_W32);

  // Lanes past the end of the transfer are zeroed; data is only driven while
  // the DATA state presents a beat.
  always_comb begin
    beat_data = '0;
    if (state_q == DATA) begin
      for (int k = 0; k < BEAT_WORDS; k++) begin
        if (remaining > 32'(k)) begin
          beat_data[32*k +: 32] = base_word + 32'(k);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      len_q     <= '0;
      off_q     <= '0;
      last_q    <= 1'b0;
      seed_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      off_q     <= off_d;
      last_q    <= last_d;
      seed_q    <= seed_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic. TIMEOUT is registered so that it pulses in the first
  // IDLE cycle, when CHNL_RX and BUSY have already dropped.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    off_d     = off_q;
    last_d    = last_q;
    seed_d    = seed_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          len_d   = CMD_LEN;
          off_d   = CMD_OFF;
          last_d  = CMD_LAST;
          seed_d  = CMD_SEED;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (CHNL_RX_ACK) begin
          state_d = (len_q == 32'd0) ? FIN : DATA;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      DATA: begin
        if (CHNL_RX_DATA_REN) begin
          if (last_beat) begin
            state_d = FIN;
          end else begin
            cnt_d = cnt_q + BEAT_W32;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign CHNL_RX_CLK        = CLK;
  assign BUSY               = (state_q != IDLE);
  assign DONE               = (state_q == FIN);
  assign TIMEOUT            = timeout_q;
  assign CHNL_RX            = (state_q == REQ) || (state_q == DATA);
  assign CHNL_RX_DATA_VALID = (state_q == DATA);
  assign CHNL_RX_DATA       = beat_data;
  assign CHNL_RX_LEN        = len_q;
  assign CHNL_RX_OFF        = off_q;
  assign CHNL_RX_LAST       = last_q;

endmodule

// File: tb/tb_chnl_rx_driver.sv
// ---------------------------------------------------------------------------
// tb_chnl_rx_driver
//   Directed bench for chnl_rx_driver (128-bit beats, 16-cycle ACK timeout).
//   Stimulus pushes the hand-computed beats and completion events it expects
//   into queues; a monitor on the falling edge pops and compares whenever a
//   beat transfers or DONE/TIMEOUT pulses, and checks that stalled beats hold.
// ---------------------------------------------------------------------------
module tb_chnl_rx_driver;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [31:0]  CMD_LEN = '0;
  logic [30:0]  CMD_OFF = '0;
  logic         CMD_LAST = 1'b0;
  logic [31:0]  CMD_SEED = '0;
  logic         BUSY, DONE, TIMEOUT, CHNL_RX_CLK, CHNL_RX;
  logic         CHNL_RX_ACK = 1'b0;
  logic         CHNL_RX_LAST;
  logic [31:0]  CHNL_RX_LEN;
  logic [30:0]  CHNL_RX_OFF;
  logic [127:0] CHNL_RX_DATA;
  logic         CHNL_RX_DATA_VALID;
  logic         CHNL_RX_DATA_REN = 1'b0;

  chnl_rx_driver #(
    .C_PCI_DATA_WIDTH(128),
    .C_ACK_TIMEOUT   (16)
  ) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .START             (START),
    .CMD_LEN           (CMD_LEN),
    .CMD_OFF           (CMD_OFF),
    .CMD_LAST          (CMD_LAST),
    .CMD_SEED          (CMD_SEED),
    .BUSY              (BUSY),
    .DONE              (DONE),
    .TIMEOUT           (TIMEOUT),
    .CHNL_RX_CLK       (CHNL_RX_CLK),
    .CHNL_RX           (CHNL_RX),
    .CHNL_RX_ACK       (CHNL_RX_ACK),
    .CHNL_RX_LAST      (CHNL_RX_LAST),
    .CHNL_RX_LEN       (CHNL_RX_LEN),
    .CHNL_RX_OFF       (CHNL_RX_OFF),
    .CHNL_RX_DATA      (CHNL_RX_DATA),
    .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID),
    .CHNL_RX_DATA_REN  (CHNL_RX_DATA_REN)
  );

  always #5 CLK = ~CLK;

  localparam logic [1:0] EV_DONE    = 2'b01;
  localparam logic [1:0] EV_TIMEOUT = 2'b10;

  logic [127:0] exp_beats[$];
  logic [1:0]   exp_events[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           valid_cycles = 0;
  logic         stall_pending = 1'b0;
  logic [127:0] stall_data = '0;
  int           cyc;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s", name);
  endtask

  // Monitor: pops the scoreboard on every beat transfer and completion pulse,
  // and verifies a beat left waiting by REN=0 is presented unchanged.
  always @(negedge CLK) begin
    if (CHNL_RX_DATA_VALID) valid_cycles++;
    if (stall_pending && CHNL_RX_DATA_VALID)
      checkOutput("stall_hold", CHNL_RX_DATA, stall_data);
    stall_pending = CHNL_RX_DATA_VALID && !CHNL_RX_DATA_REN;
    stall_data    = CHNL_RX_DATA;
    if (CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN) begin
      if (exp_beats.size() == 0) begin
        reportFail($sformatf("unexpected_beat got %h", CHNL_RX_DATA));
      end else begin
        checkOutput("beat", CHNL_RX_DATA, exp_beats.pop_front());
      end
    end
    if (DONE || TIMEOUT) begin
      if (exp_events.size() == 0) begin
        reportFail($sformatf("unexpected_event done=%b timeout=%b", DONE, TIMEOUT));
      end else begin
        checkOutput("event", {126'd0, TIMEOUT, DONE}, {126'd0, exp_events.pop_front()});
      end
    end
  end

  // Issues one START strobe; assumes it is called just after a rising edge.
  task automatic applyStimulus(input logic [31:0] len, input logic [30:0] off,
                               input logic last, input logic [31:0] seed);
    CMD_LEN  = len;
    CMD_OFF  = off;
    CMD_LAST = last;
    CMD_SEED = seed;
    START    = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    checkOutput("busy_after_start", {127'd0, BUSY}, 128'd1);
  endtask

  // Drives ACK/REN until the command finishes; ren_mode 0 = REN high,
  // 1 = REN toggling 1010, 2 = REN low then high with a stray START.
  task automatic runXfer(input int ack_delay, input int ren_mode, output int cycles);
    cycles = 0;
    while (BUSY && cycles < 200) begin
      CHNL_RX_ACK = (cycles >= ack_delay);
      case (ren_mode)
        0: CHNL_RX_DATA_REN = 1'b1;
        1: CHNL_RX_DATA_REN = (cycles % 2 == 0);
        default: begin
          CHNL_RX_DATA_REN = (cycles >= 5);
          if (cycles == 3) begin
            CMD_LEN  = 32'd3;
            CMD_SEED = 32'h999;
            START    = 1'b1;
          end
        end
      endcase
      @(posedge CLK); #1;
      START = 1'b0;
      cycles++;
    end
    if (BUSY) reportFail("xfer_cycle_budget_expired");
    CHNL_RX_ACK      = 1'b0;
    CHNL_RX_DATA_REN = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    checkOutput("rst_busy", {127'd0, BUSY}, 128'd0);
    checkOutput("rst_done_timeout", {126'd0, DONE, TIMEOUT}, 128'd0);
    checkOutput("rst_rx_valid", {126'd0, CHNL_RX, CHNL_RX_DATA_VALID}, 128'd0);
    checkOutput("rst_len", {96'd0, CHNL_RX_LEN}, 128'd0);
    checkOutput("rst_off_last", {96'd0, CHNL_RX_OFF, CHNL_RX_LAST}, 128'd0);
    checkOutput("rst_data", CHNL_RX_DATA, 128'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // 1: LEN=8, SEED=0x100, ACK on third REQ cycle, REN always high
    $display("[TB] test 1: basic two-beat transfer");
    exp_beats.push_back(128'h00000103_00000102_00000101_00000100);
    exp_beats.push_back(128'h00000107_00000106_00000105_00000104);
    exp_events.push_back(EV_DONE);
    applyStimulus(32'd8, 31'h1234, 1'b1, 32'h100);
    checkOutput("t1_req_open", {126'd0, CHNL_RX, CHNL_RX_DATA_VALID}, 128'd2);
    checkOutput("t1_len", {96'd0, CHNL_RX_LEN}, 128'd8);
    checkOutput("t1_off_last", {96'd0, CHNL_RX_OFF, CHNL_RX_LAST}, {96'd0, 31'h1234, 1'b1});
    runXfer(2, 0, cyc);
    checkOutput("t1_cycles", 128'(cyc), 128'd6);
    checkOutput("t1_rx_closed", {127'd0, CHNL_RX}, 128'd0);
    checkOutput("t1_len_kept", {96'd0, CHNL_RX_LEN}, 128'd8);

    // 2: LEN=5, REN toggling
    $display("[TB] test 2: partial beat with REN toggling");
    exp_beats.push_back(128'h00000023_00000022_00000021_00000020);
    exp_beats.push_back(128'h00000000_00000000_00000000_00000024);
    exp_events.push_back(EV_DONE);
    applyStimulus(32'd5, 31'd0, 1'b0, 32'h20);
    runXfer(0, 1, cyc);
    checkOutput("t2_cycles", 128'(cyc), 128'd6);

    // 3: LEN=0 goes straight to FIN
    $display("[TB] test 3: zero length");
    valid_cycles = 0;
    exp_events.push_back(EV_DONE);
    applyStimulus(32'd0, 31'd7, 1'b1, 32'h55);
    runXfer(0, 0, cyc);
    checkOutput("t3_cycles", 128'(cyc), 128'd2);
    checkOutput("t3_no_valid", 128'(valid_cycles), 128'd0);

    // 4: ACK never comes -> TIMEOUT after 16 REQ cycles, then immediate restart
    $display("[TB] test 4: acknowledge timeout");
    exp_events.push_back(EV_TIMEOUT);
    applyStimulus(32'd4, 31'd0, 1'b0, 32'h300);
    runXfer(1000, 0, cyc);
    checkOutput("t4_req_cycles", 128'(cyc), 128'd16);
    checkOutput("t4_timeout_pulse", {125'd0, TIMEOUT, CHNL_RX, BUSY}, 128'd4);
    exp_beats.push_back(128'h00000303_00000302_00000301_00000300);
    exp_events.push_back(EV_DONE);
    applyStimulus(32'd4, 31'd0, 1'b0, 32'h300);
    runXfer(0, 0, cyc);
    checkOutput("t4_restart_cycles", 128'(cyc), 128'd3);

    // 5: seed wrap-around, then a START pulsed mid-DATA
    $display("[TB] test 5: seed wrap and ignored START");
    exp_beats.push_back(128'h00000001_00000000_FFFFFFFF_FFFFFFFE);
    exp_events.push_back(EV_DONE);
    applyStimulus(32'd4, 31'd0, 1'b0, 32'hFFFFFFFE);
    runXfer(0, 0, cyc);
    exp_beats.push_back(128'h00000403_00000402_00000401_00000400);
    exp_beats.push_back(128'h00000407_00000406_00000405_00000404);
    exp_events.push_back(EV_DONE);
    applyStimulus(32'd8, 31'd0, 1'b0, 32'h400);
    runXfer(0, 2, cyc);
    checkOutput("t5_cycles", 128'(cyc), 128'd8);
    checkOutput("t5_len_unchanged", {96'd0, CHNL_RX_LEN}, 128'd8);

    // 6: asynchronous reset in DATA, then a normal transfer
    $display("[TB] test 6: reset mid-transfer");
    applyStimulus(32'd8, 31'd9, 1'b1, 32'h200);
    CHNL_RX_ACK = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checkOutput("t6_in_data", {126'd0, CHNL_RX, CHNL_RX_DATA_VALID}, 128'd3);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("t6_rst_rx_valid_busy", {125'd0, CHNL_RX, CHNL_RX_DATA_VALID, BUSY}, 128'd0);
    checkOutput("t6_rst_len_off", {64'd0, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_LAST}, 128'd0);
    checkOutput("t6_rst_data", CHNL_RX_DATA, 128'd0);
    CHNL_RX_ACK = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    exp_beats.push_back(128'h00000053_00000052_00000051_00000050);
    exp_events.push_back(EV_DONE);
    applyStimulus(32'd4, 31'd0, 1'b0, 32'h50);
    runXfer(0, 0, cyc);
    checkOutput("t6_after_reset_cycles", 128'(cyc), 128'd3);

    @(posedge CLK); #1;
    checkOutput("beats_drained", 128'(exp_beats.size()), 128'd0);
    checkOutput("events_drained", 128'(exp_events.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
